// File: rtl/vga_sync_monitor_pkg.sv
// Shared constants, FSM state encoding and small arithmetic helpers for the
// VGA sync monitor. Default timing is 640x480@60 expressed in 50 MHz clocks.
package vga_sync_monitor_pkg;

    localparam int H_TOTAL_DEF     = 1600;
    localparam int H_SYNC_DEF      = 192;
    localparam int V_TOTAL_DEF     = 525;
    localparam int V_SYNC_DEF      = 2;
    localparam int TOL_DEF         = 4;
    localparam int LOCK_FRAMES_DEF = 2;

    localparam logic [11:0] HCNT_MAX = 12'hFFF;
    localparam logic [9:0]  VCNT_MAX = 10'h3FF;
    localparam logic [7:0]  ERR_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == HCNT_MAX) ? v : v + 12'd1;
    endfunction

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == VCNT_MAX) ? v : v + 10'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == ERR_MAX) ? v : v + 8'd1;
    endfunction

    // |meas - nominal| > tol, evaluated in 13-bit signed so a short
    // measurement cannot wrap into a large positive difference.
    function automatic logic out_of_tol(input logic [11:0] meas,
                                        input logic [11:0] nominal,
                                        input logic [11:0] tol);
        logic signed [12:0] diff;
        logic signed [12:0] mag;
        diff = $signed({1'b0, meas}) - $signed({1'b0, nominal});
        mag  = (diff < 0) ? -diff : diff;
        return mag > $signed({1'b0, tol});
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Brings one asynchronous active-low sync line into the clock domain and
// flags its falling and rising edges. Flops idle high so reset looks like
// an inactive sync rather than a fresh pulse.
module vga_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic fall,
    output logic rise
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic dly_q,  dly_d;

    // Two-stage synchronizer followed by a one-cycle delay for edge detection.
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        dly_d  = sync_q;
    end

    // Synchronizer and delay registers, reset to the idle-high level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            dly_q  <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign fall = dly_q & ~sync_q;
    assign rise = ~dly_q & sync_q;

endmodule

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: measures line period, hsync width, lines
// per frame and vsync width, tracks conformance over whole frames and
// declares lock after LOCK_FRAMES consecutive good frames. Also exports the
// live raster position and per-line / per-frame strobes.
module vga_sync_monitor
    import vga_sync_monitor_pkg::*;
#(
    parameter int H_TOTAL     = H_TOTAL_DEF,
    parameter int H_SYNC      = H_SYNC_DEF,
    parameter int V_TOTAL     = V_TOTAL_DEF,
    parameter int V_SYNC      = V_SYNC_DEF,
    parameter int TOL         = TOL_DEF,
    parameter int LOCK_FRAMES = LOCK_FRAMES_DEF
) (
    input  logic        clk50M,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic        locked,
    output logic        line_tick,
    output logic        frame_tick,
    output logic [11:0] hpos,
    output logic [9:0]  vpos,
    output logic [11:0] h_period,
    output logic [11:0] h_width,
    output logic [9:0]  v_lines,
    output logic [9:0]  v_width,
    output logic [7:0]  err_cnt,
    output logic [1:0]  dbg_state
);

    localparam logic [11:0] H_TOTAL_L = 12'(H_TOTAL);
    localparam logic [11:0] H_SYNC_L  = 12'(H_SYNC);
    localparam logic [11:0] TOL_L     = 12'(TOL);
    localparam logic [9:0]  V_TOTAL_L = 10'(V_TOTAL);
    localparam logic [9:0]  V_SYNC_L  = 10'(V_SYNC);
    localparam logic [7:0]  LOCK_L    = 8'(LOCK_FRAMES);

    logic h_fall, h_rise, v_fall, v_rise;

    vga_sync_edge u_hsync_edge (
        .clk      (clk50M),
        .rst      (rst),
        .async_in (hsync_in),
        .fall     (h_fall),
        .rise     (h_rise)
    );

    vga_sync_edge u_vsync_edge (
        .clk      (clk50M),
        .rst      (rst),
        .async_in (vsync_in),
        .fall     (v_fall),
        .rise     (v_rise)
    );

    // Measurement state
    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] h_period_q, h_period_d;
    logic [11:0] h_width_q, h_width_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [9:0]  v_lines_q, v_lines_d;
    logic [9:0]  vw_cnt_q, vw_cnt_d;
    logic [9:0]  v_width_q, v_width_d;
    logic        bad_q, bad_d;
    logic        line_tick_q, line_tick_d;
    logic        frame_tick_q, frame_tick_d;
    logic        frame_good_q, frame_good_d;

    // Tracking state
    state_e      state_q, state_d;
    logic [7:0]  good_cnt_q, good_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        locked_q, locked_d;

    logic [11:0] h_cnt_inc;
    logic [9:0]  lines_now;
    logic        bad_now;

    // Per-edge measurements. The clock count is taken as h_cnt+1 so that the
    // fall-to-fall distance and the fall-to-rise distance are both in whole
    // clocks. An hsync fall landing on a vsync fall belongs to the frame that
    // is ending, so it is folded into the line count and bad flag first.
    always_comb begin
        h_cnt_inc = sat_inc12(h_cnt_q);
        h_cnt_d   = h_fall ? 12'd0 : h_cnt_inc;
        h_period_d = h_fall ? h_cnt_inc : h_period_q;
        h_width_d  = h_rise ? h_cnt_inc : h_width_q;

        bad_now = bad_q
                | (h_fall && out_of_tol(h_cnt_inc, H_TOTAL_L, TOL_L))
                | (h_rise && out_of_tol(h_cnt_inc, H_SYNC_L, TOL_L));

        lines_now = h_fall ? sat_inc10(v_cnt_q) : v_cnt_q;
        v_cnt_d   = v_fall ? 10'd0 : lines_now;
        v_lines_d = v_fall ? lines_now : v_lines_q;

        // vsync width counts hsync falls in [vsync fall, vsync rise)
        vw_cnt_d = vw_cnt_q;
        if (v_fall) begin
            vw_cnt_d = {9'd0, h_fall};
        end else if (h_fall) begin
            vw_cnt_d = sat_inc10(vw_cnt_q);
        end
        v_width_d = v_rise ? vw_cnt_q : v_width_q;

        frame_good_d = !bad_now && (lines_now == V_TOTAL_L) && (v_width_q == V_SYNC_L);
        bad_d        = v_fall ? 1'b0 : bad_now;

        line_tick_d  = h_fall;
        frame_tick_d = v_fall;
    end

    // Measurement registers; all update on the same edge as the tick.
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            h_cnt_q      <= '0;
            h_period_q   <= '0;
            h_width_q    <= '0;
            v_cnt_q      <= '0;
            v_lines_q    <= '0;
            vw_cnt_q     <= '0;
            v_width_q    <= '0;
            bad_q        <= 1'b0;
            line_tick_q  <= 1'b0;
            frame_tick_q <= 1'b0;
            frame_good_q <= 1'b0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            h_period_q   <= h_period_d;
            h_width_q    <= h_width_d;
            v_cnt_q      <= v_cnt_d;
            v_lines_q    <= v_lines_d;
            vw_cnt_q     <= vw_cnt_d;
            v_width_q    <= v_width_d;
            bad_q        <= bad_d;
            line_tick_q  <= line_tick_d;
            frame_tick_q <= frame_tick_d;
            frame_good_q <= frame_good_d;
        end
    end

    // Lock tracker, driven by the registered frame verdict so it reacts one
    // cycle after frame_tick. A saturated line counter means hsync has gone
    // away and overrides any frame verdict.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (h_cnt_q == HCNT_MAX) begin
            state_d    = ST_SEARCH;
            good_cnt_d = 8'd0;
            if (state_q == ST_LOCKED) begin
                err_cnt_d = sat_inc8(err_cnt_q);
            end
        end else if (frame_tick_q) begin
            case (state_q)
                ST_SEARCH: begin
                    state_d    = ST_TRACK;
                    good_cnt_d = 8'd0;
                end
                ST_TRACK: begin
                    if (frame_good_q) begin
                        good_cnt_d = sat_inc8(good_cnt_q);
                        if (sat_inc8(good_cnt_q) >= LOCK_L) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        good_cnt_d = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    if (!frame_good_q) begin
                        err_cnt_d  = sat_inc8(err_cnt_q);
                        state_d    = ST_TRACK;
                        good_cnt_d = 8'd0;
                    end
                end
                default: begin
                    state_d    = ST_SEARCH;
                    good_cnt_d = 8'd0;
                end
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    // Tracker registers.
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            state_q    <= ST_SEARCH;
            good_cnt_q <= '0;
            err_cnt_q  <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            err_cnt_q  <= err_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign locked     = locked_q;
    assign line_tick  = line_tick_q;
    assign frame_tick = frame_tick_q;
    assign hpos       = h_cnt_q;
    assign vpos       = v_cnt_q;
    assign h_period   = h_period_q;
    assign h_width    = h_width_q;
    assign v_lines    = v_lines_q;
    assign v_width    = v_width_q;
    assign err_cnt    = err_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor using a scaled-down raster (40 clocks x 12
// lines) so many frames fit in a short run. A reference model derives every
// output from the sampled input history with plain arithmetic on cycle
// timestamps; a negedge process compares DUT outputs with it every cycle.
module tb_vga_sync_monitor;

    localparam int HT = 40;
    localparam int HS = 6;
    localparam int VT = 12;
    localparam int VS = 2;
    localparam int TL = 2;
    localparam int LF = 2;
    localparam int W  = 77;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        locked, line_tick, frame_tick;
    logic [11:0] hpos, h_period, h_width;
    logic [9:0]  vpos, v_lines, v_width;
    logic [7:0]  err_cnt;
    logic [1:0]  dbg_state;

    vga_sync_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .V_SYNC(VS),
        .TOL(TL), .LOCK_FRAMES(LF)
    ) dut (
        .clk50M     (clk),
        .rst        (rst),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .locked     (locked),
        .line_tick  (line_tick),
        .frame_tick (frame_tick),
        .hpos       (hpos),
        .vpos       (vpos),
        .h_period   (h_period),
        .h_width    (h_width),
        .v_lines    (v_lines),
        .v_width    (v_width),
        .err_cnt    (err_cnt),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters / scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_q[$];
    bit ever_locked = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit hh[4];
    bit vh[4];
    int cyc, last_hf, prev_hpos, m_hpos;
    int m_period, m_width, m_lines_run, m_vlines, m_vw_run, m_vwidth;
    int m_err, m_run;
    bit m_frame_bad, m_acquired, m_locked, pend_vf, pend_good, m_ltick, m_ftick;

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int cap(input int x, input int mx);
        return (x > mx) ? mx : x;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            hh[i] = 1'b1;
            vh[i] = 1'b1;
        end
        cyc = 0; last_hf = 0; prev_hpos = 0; m_hpos = 0;
        m_period = 0; m_width = 0; m_lines_run = 0; m_vlines = 0;
        m_vw_run = 0; m_vwidth = 0; m_err = 0; m_run = 0;
        m_frame_bad = 0; m_acquired = 0; m_locked = 0;
        pend_vf = 0; pend_good = 0; m_ltick = 0; m_ftick = 0;
    endfunction

    function automatic void model_step(input bit hs, input bit vs);
        bit hf, hr, vf, vr;
        int elapsed;
        for (int i = 3; i > 0; i--) begin
            hh[i] = hh[i-1];
            vh[i] = vh[i-1];
        end
        hh[0] = hs;
        vh[0] = vs;
        cyc++;
        // an input edge first seen three samples ago shows up now
        hf = hh[3] && !hh[2];
        hr = !hh[3] && hh[2];
        vf = vh[3] && !vh[2];
        vr = !vh[3] && vh[2];

        // lock decisions react to what was observed one cycle earlier
        if (prev_hpos == 4095) begin
            if (m_locked) m_err = cap(m_err + 1, 255);
            m_locked = 0; m_acquired = 0; m_run = 0;
        end else if (pend_vf) begin
            if (!m_acquired) begin
                m_acquired = 1; m_run = 0;
            end else if (pend_good) begin
                if (!m_locked) begin
                    m_run++;
                    if (m_run >= LF) m_locked = 1;
                end
            end else begin
                if (m_locked) m_err = cap(m_err + 1, 255);
                m_locked = 0; m_run = 0;
            end
        end

        elapsed = cap(cyc - last_hf, 4095);
        if (hf) begin
            m_period = elapsed;
            if (iabs(m_period - HT) > TL) m_frame_bad = 1;
            last_hf = cyc;
            m_lines_run = cap(m_lines_run + 1, 1023);
        end
        if (hr) begin
            m_width = elapsed;
            if (iabs(m_width - HS) > TL) m_frame_bad = 1;
        end
        if (vr) m_vwidth = m_vw_run;
        if (vf) begin
            pend_good = !m_frame_bad && (m_lines_run == VT) && (m_vwidth == VS);
            m_vlines = m_lines_run;
            m_lines_run = 0;
            m_frame_bad = 0;
            m_vw_run = hf ? 1 : 0;
        end else if (hf) begin
            m_vw_run = cap(m_vw_run + 1, 1023);
        end
        pend_vf = vf;
        m_ltick = hf;
        m_ftick = vf;
        m_hpos = cap(cyc - last_hf, 4095);
        prev_hpos = m_hpos;
    endfunction

    function automatic logic [W-1:0] model_vec();
        return {m_locked, m_ltick, m_ftick, 12'(m_hpos), 10'(m_lines_run),
                12'(m_period), 12'(m_width), 10'(m_vlines), 10'(m_vwidth), 8'(m_err)};
    endfunction

    // Model advances on every active edge from the sampled inputs.
    always @(posedge clk) begin
        if (rst) begin
            model_reset();
            exp_q.push_back('0);
        end else begin
            model_step(hsync_in, vsync_in);
            exp_q.push_back(model_vec());
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {locked, line_tick, frame_tick, hpos, vpos, h_period,
                     h_width, v_lines, v_width, err_cnt};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_fail++;
                if (n_fail <= 20)
                    $display("FAIL cycle_model t=%0t got=%h expected=%h (lock,lt,ft,hpos,vpos,hper,hwid,vlin,vwid,err)",
                             $time, act_v, exp_v);
            end
            if (locked === 1'b1) ever_locked = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hsync_in = 1'b1;
            vsync_in = 1'b1;
        end
    endtask

    task automatic drive_line(input int period, input int width, input bit vlow);
        for (int i = 0; i < period; i++) begin
            @(negedge clk);
            hsync_in = (i < width) ? 1'b0 : 1'b1;
            vsync_in = vlow ? 1'b0 : 1'b1;
        end
    endtask

    // vsync edges aligned to hsync falls; one line may get a different period
    task automatic drive_frame(input int lines, input int period, input int odd_line, input int odd_period);
        for (int l = 0; l < lines; l++)
            drive_line((l == odd_line) ? odd_period : period, HS, l < VS);
    endtask

    task automatic drive_rand_frame();
        int lines;
        int per;
        int wid;
        lines = VT;
        if ($urandom_range(0, 4) == 0) lines = ($urandom_range(0, 1) == 1) ? VT + 1 : VT - 1;
        for (int l = 0; l < lines; l++) begin
            per = HT - TL + int'($urandom_range(0, 2 * TL));
            if ($urandom_range(0, 40) == 0) per = HT + TL + 1 + int'($urandom_range(0, 3));
            wid = HS - TL + int'($urandom_range(0, 2 * TL));
            drive_line(per, wid, l < VS);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_locked"},   32'(locked),     0);
        check({tag, "_ticks"},    32'({line_tick, frame_tick}), 0);
        check({tag, "_hpos"},     32'(hpos),       0);
        check({tag, "_vpos"},     32'(vpos),       0);
        check({tag, "_meas"},     32'(h_period | h_width), 0);
        check({tag, "_vmeas"},    32'(v_lines | v_width), 0);
        check({tag, "_err_cnt"},  32'(err_cnt),    0);
        check({tag, "_state"},    32'(dbg_state),  0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: run exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        idle($urandom_range(3, 20));

        // nominal timing: locks after the third vsync fall
        repeat (3) drive_frame(VT, HT, -1, 0);
        check("nom_locked",   32'(locked),   1);
        check("nom_h_period", 32'(h_period), HT);
        check("nom_h_width",  32'(h_width),  HS);
        check("nom_v_lines",  32'(v_lines),  VT);
        check("nom_v_width",  32'(v_width),  VS);
        check("nom_err_cnt",  32'(err_cnt),  0);

        // one stretched line loses lock at the next vsync fall
        drive_frame(VT, HT, 5, HT + 5);
        drive_frame(VT, HT, -1, 0);
        check("stretch_locked",  32'(locked),  0);
        check("stretch_err_cnt", 32'(err_cnt), 1);
        repeat (2) drive_frame(VT, HT, -1, 0);
        check("relock_locked", 32'(locked), 1);

        // period at the edge of tolerance keeps lock
        repeat (3) drive_frame(VT, HT + TL, -1, 0);
        check("tol_locked",   32'(locked),   1);
        check("tol_h_period", 32'(h_period), HT + TL);
        check("tol_err_cnt",  32'(err_cnt),  1);

        // one line short per frame never locks
        pulse_reset();
        idle($urandom_range(3, 20));
        ever_locked = 1'b0;
        repeat (5) drive_frame(VT - 1, HT, -1, 0);
        check("short_never_locked", 32'(ever_locked), 0);
        check("short_v_lines",      32'(v_lines),     VT - 1);

        // randomized jitter, width variation, odd line counts, bad lines
        repeat (8) drive_rand_frame();

        // lock, then lose hsync entirely
        repeat (3) drive_frame(VT, HT, -1, 0);
        check("pre_stall_locked", 32'(locked), 1);
        idle(4200);
        check("stall_locked",   32'(locked),    0);
        check("stall_state",    32'(dbg_state), 0);
        check("stall_h_period", 32'(h_period),  HT);

        // reset in the middle of a line while locked
        repeat (3) drive_frame(VT, HT, -1, 0);
        check("pre_rst_locked", 32'(locked), 1);
        drive_line(20, HS, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_zero("midrst");
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle($urandom_range(3, 20));
        repeat (3) drive_frame(VT, HT, -1, 0);
        check("post_rst_locked",  32'(locked),  1);
        check("post_rst_err_cnt", 32'(err_cnt), 0);
        check("post_rst_v_lines", 32'(v_lines), VT);

        idle(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
